port_stream_bridge: RTL and testbench

//  Device-side responder for one CPU I/O port pair: the peripheral end of the

---
 rtl/port_stream_bridge.sv | 147 ++++++++++++++
 tb/tb_port_stream_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/port_stream_bridge.sv
// Peripheral end of one CPU I/O port pair. CPU port writes feed a TX FIFO that drains
// to a valid/ready stream, and an inbound stream fills an RX FIFO that the CPU reads.
module port_stream_bridge #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_wr_data,
  input  logic [15:0] cpu_wr_ctrl,
  input  logic        cpu_inform_write,
  input  logic        cpu_inform_read,
  output logic [15:0] cpu_rd_data,
  output logic [15:0] cpu_rd_status,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   tx_mem_q [DEPTH];
  logic [15:0]   tx_mem_d [DEPTH];
  logic [15:0]   rx_mem_q [DEPTH];
  logic [15:0]   rx_mem_d [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic          tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [15:0]   cpu_rd_data_q, cpu_rd_data_d;
  logic [15:0]   cpu_rd_status_q, cpu_rd_status_d;

  logic cmd, flush, clr_flags;
  logic tx_push_req, tx_push, tx_pop, tx_drop;
  logic rx_push, rx_pop, rx_under;

  // Only bits [2:0] of the control word carry meaning.
  logic unused_ctrl;
  assign unused_ctrl = ^cpu_wr_ctrl[15:3];

  always_comb begin
    cmd         = cpu_inform_write & cpu_wr_ctrl[0];
    flush       = cmd & cpu_wr_ctrl[2];
    clr_flags   = cmd & cpu_wr_ctrl[1];

    tx_pop      = (tx_count_q != '0) & tx_ready;
    tx_push_req = cpu_inform_write & ~cpu_wr_ctrl[0];
    tx_push     = tx_push_req & ((tx_count_q != FULL) | tx_pop);
    tx_drop     = tx_push_req & ~tx_push;

    rx_push     = rx_valid & (rx_count_q != FULL) & ~flush;
    rx_pop      = cpu_inform_read & (rx_count_q != '0);
    rx_under    = cpu_inform_read & (rx_count_q == '0);

    tx_mem_d   = tx_mem_q;
    rx_mem_d   = rx_mem_q;
    tx_wptr_d  = tx_wptr_q;
    tx_rptr_d  = tx_rptr_q;
    rx_wptr_d  = rx_wptr_q;
    rx_rptr_d  = rx_rptr_q;
    tx_count_d = tx_count_q;
    rx_count_d = rx_count_q;
    tx_ovf_d   = tx_ovf_q;
    rx_unf_d   = rx_unf_q;

    if (tx_push) begin
      tx_mem_d[tx_wptr_q] = cpu_wr_data;
      tx_wptr_d           = tx_wptr_q + AW'(1);
    end
    if (tx_pop) tx_rptr_d = tx_rptr_q + AW'(1);
    if (tx_push && !tx_pop)      tx_count_d = tx_count_q + CW'(1);
    else if (!tx_push && tx_pop) tx_count_d = tx_count_q - CW'(1);

    if (rx_push) begin
      rx_mem_d[rx_wptr_q] = rx_data;
      rx_wptr_d           = rx_wptr_q + AW'(1);
    end
    if (rx_pop) rx_rptr_d = rx_rptr_q + AW'(1);
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + CW'(1);
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CW'(1);

    // A clear and a fresh event in the same cycle leave the flag set.
    if (clr_flags) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (tx_drop)  tx_ovf_d = 1'b1;
    if (rx_under) rx_unf_d = 1'b1;

    if (flush) begin
      tx_wptr_d  = '0;
      tx_rptr_d  = '0;
      rx_wptr_d  = '0;
      rx_rptr_d  = '0;
      tx_count_d = '0;
      rx_count_d = '0;
    end

    if (flush)                  cpu_rd_data_d = 16'h0000;
    else if (rx_count_d != '0)  cpu_rd_data_d = rx_mem_d[rx_rptr_d];
    else                        cpu_rd_data_d = cpu_rd_data_q;

    cpu_rd_status_d = {tx_ovf_d, rx_unf_d, (rx_count_d != '0), (tx_count_d == FULL),
                       6'(rx_count_d), 6'(tx_count_d)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_mem_q        <= '{default: '0};
      rx_mem_q        <= '{default: '0};
      tx_wptr_q       <= '0;
      tx_rptr_q       <= '0;
      rx_wptr_q       <= '0;
      rx_rptr_q       <= '0;
      tx_count_q      <= '0;
      rx_count_q      <= '0;
      tx_ovf_q        <= 1'b0;
      rx_unf_q        <= 1'b0;
      cpu_rd_data_q   <= 16'h0000;
      cpu_rd_status_q <= 16'h0000;
    end else begin
      tx_mem_q        <= tx_mem_d;
      rx_mem_q        <= rx_mem_d;
      tx_wptr_q       <= tx_wptr_d;
      tx_rptr_q       <= tx_rptr_d;
      rx_wptr_q       <= rx_wptr_d;
      rx_rptr_q       <= rx_rptr_d;
      tx_count_q      <= tx_count_d;
      rx_count_q      <= rx_count_d;
      tx_ovf_q        <= tx_ovf_d;
      rx_unf_q        <= rx_unf_d;
      cpu_rd_data_q   <= cpu_rd_data_d;
      cpu_rd_status_q <= cpu_rd_status_d;
    end
  end

  assign cpu_rd_data   = cpu_rd_data_q;
  assign cpu_rd_status = cpu_rd_status_q;
  assign tx_valid      = (tx_count_q != '0);
  assign tx_data       = tx_mem_q[tx_rptr_q];
  assign rx_ready      = (rx_count_q != FULL);

endmodule

// File: tb/tb_port_stream_bridge.sv
// Directed bench for port_stream_bridge (DEPTH=8): reset, TX overflow and drain,
// RX read/underflow, full-FIFO push-with-pop, RX refill and flush.
module tb_port_stream_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_wr_data, cpu_wr_ctrl;
  logic        cpu_inform_write, cpu_inform_read;
  logic [15:0] cpu_rd_data, cpu_rd_status;
  logic [15:0] tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid, rx_ready;

  int n_cmp = 0;
  int n_bad = 0;

  port_stream_bridge #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_ctrl(cpu_wr_ctrl),
    .cpu_inform_write(cpu_inform_write), .cpu_inform_read(cpu_inform_read),
    .cpu_rd_data(cpu_rd_data), .cpu_rd_status(cpu_rd_status),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] data, input logic [15:0] ctrl);
    cpu_wr_data      = data;
    cpu_wr_ctrl      = ctrl;
    cpu_inform_write = 1'b1;
    tick();
    cpu_inform_write = 1'b0;
  endtask

  task automatic cpu_read();
    cpu_inform_read = 1'b1;
    tick();
    cpu_inform_read = 1'b0;
  endtask

  task automatic rx_send(input logic [15:0] data);
    rx_data  = data;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_wr_data = '0; cpu_wr_ctrl = '0;
    cpu_inform_write = 1'b0; cpu_inform_read = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    repeat (2) tick();
    check("rst_status", cpu_rd_status, 16'h0000);
    check("rst_rd_data", cpu_rd_data, 16'h0000);
    check("rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    check("rst_rx_ready", {15'd0, rx_ready}, 16'h0001);
    rst_n = 1'b1;
    tick();

    // 1: traffic, then async reset between edges
    cpu_wr_data = 16'h1234; cpu_wr_ctrl = 16'h0000; cpu_inform_write = 1'b1;
    rx_data = 16'hCAFE; rx_valid = 1'b1;
    tick();
    cpu_inform_write = 1'b0; rx_valid = 1'b0;
    check("t1_status", cpu_rd_status, 16'h2041);
    check("t1_rd_data", cpu_rd_data, 16'hCAFE);
    check("t1_tx_data", tx_data, 16'h1234);
    check("t1_tx_valid", {15'd0, tx_valid}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("t1_mid_rst_status", cpu_rd_status, 16'h0000);
    check("t1_mid_rst_rd_data", cpu_rd_data, 16'h0000);
    check("t1_mid_rst_tx_valid", {15'd0, tx_valid}, 16'h0000);
    check("t1_mid_rst_rx_ready", {15'd0, rx_ready}, 16'h0001);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: overflow with sink stalled, then ordered drain
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) cpu_write(16'(16'h1111 + i), 16'h0000);
    check("t2_full_status", cpu_rd_status, 16'h1008);
    cpu_write(16'h1119, 16'h0000);
    check("t2_ovf_status", cpu_rd_status, 16'h9008);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("t2_drain_valid", {15'd0, tx_valid}, 16'h0001);
      check("t2_drain_data", tx_data, 16'(16'h1111 + i));
      tick();
    end
    tx_ready = 1'b0;
    check("t2_empty_valid", {15'd0, tx_valid}, 16'h0000);
    check("t2_sticky_status", cpu_rd_status, 16'h8000);
    cpu_write(16'h0000, 16'h0003);
    check("t2_clear_status", cpu_rd_status, 16'h0000);

    // 3: RX words read back, third read underflows
    rx_send(16'hA0A0);
    rx_send(16'hB0B0);
    check("t3_rd0", cpu_rd_data, 16'hA0A0);
    check("t3_status0", cpu_rd_status, 16'h2080);
    cpu_read();
    check("t3_rd1", cpu_rd_data, 16'hB0B0);
    check("t3_status1", cpu_rd_status, 16'h2040);
    cpu_read();
    check("t3_rd2", cpu_rd_data, 16'hB0B0);
    check("t3_status2", cpu_rd_status, 16'h0000);
    cpu_read();
    check("t3_unf_rd", cpu_rd_data, 16'hB0B0);
    check("t3_unf_status", cpu_rd_status, 16'h4000);
    cpu_write(16'h0000, 16'h0003);
    check("t3_clear_status", cpu_rd_status, 16'h0000);

    // 4: push into full TX in the same cycle as a pop
    for (int i = 0; i < 8; i++) cpu_write(16'(16'h4001 + i), 16'h0000);
    check("t4_full_status", cpu_rd_status, 16'h1008);
    check("t4_head", tx_data, 16'h4001);
    tx_ready = 1'b1;
    cpu_write(16'h5555, 16'h0000);
    check("t4_status_after", cpu_rd_status, 16'h1008);
    for (int i = 0; i < 7; i++) begin
      check("t4_drain_data", tx_data, 16'(16'h4002 + i));
      tick();
    end
    check("t4_last_data", tx_data, 16'h5555);
    check("t4_last_valid", {15'd0, tx_valid}, 16'h0001);
    tick();
    tx_ready = 1'b0;
    check("t4_empty_valid", {15'd0, tx_valid}, 16'h0000);
    check("t4_empty_status", cpu_rd_status, 16'h0000);

    // underflow now so both flags are set later
    cpu_read();
    check("t5_pre_unf", cpu_rd_status, 16'h4000);

    // 5: fill RX, read while offered word is stalled, then refill
    for (int i = 0; i < 8; i++) rx_send(16'(16'hC000 + i));
    check("t5_full_ready", {15'd0, rx_ready}, 16'h0000);
    check("t5_full_status", cpu_rd_status, 16'h6200);
    check("t5_full_rd", cpu_rd_data, 16'hC000);
    rx_data = 16'hC008; rx_valid = 1'b1;
    cpu_read();
    check("t5_after_read_ready", {15'd0, rx_ready}, 16'h0001);
    check("t5_after_read_status", cpu_rd_status, 16'h61C0);
    check("t5_after_read_rd", cpu_rd_data, 16'hC001);
    tick();
    rx_valid = 1'b0;
    check("t5_refill_ready", {15'd0, rx_ready}, 16'h0000);
    check("t5_refill_status", cpu_rd_status, 16'h6200);

    // 6: overflow TX too, then flush+clear with an RX word offered
    for (int i = 0; i < 9; i++) cpu_write(16'(16'h7000 + i), 16'h0000);
    check("t6_pre_status", cpu_rd_status, 16'hF208);
    check("t6_pre_tx_data", tx_data, 16'h7000);
    rx_data = 16'hDEAD; rx_valid = 1'b1;
    cpu_write(16'h0000, 16'h0007);
    rx_valid = 1'b0;
    check("t6_flush_status", cpu_rd_status, 16'h0000);
    check("t6_flush_rd", cpu_rd_data, 16'h0000);
    check("t6_flush_tx_valid", {15'd0, tx_valid}, 16'h0000);
    check("t6_flush_rx_ready", {15'd0, rx_ready}, 16'h0001);
    tick();
    check("t6_dropped_status", cpu_rd_status, 16'h0000);

    // flush alone keeps sticky flags
    cpu_read();
    rx_send(16'h3333);
    check("t7_pre_status", cpu_rd_status, 16'h6040);
    cpu_write(16'h0000, 16'h0005);
    check("t7_flush_keeps_flag", cpu_rd_status, 16'h4000);
    check("t7_flush_rd", cpu_rd_data, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
